// File: rtl/dcc_bit_encoder.sv
// DCC physical-layer encoder: turns one logical bit at a time into the NMRA
// two-half-period waveform and drives complementary H-bridge legs with dead-time.
module dcc_bit_encoder #(
    parameter int unsigned CLK_FREQ_HZ  = 50_000_000,
    parameter int unsigned ONE_HALF_US  = 58,
    parameter int unsigned ZERO_HALF_US = 100,
    parameter int unsigned DEAD_CYCLES  = 8,
    parameter int unsigned CNT_W        = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic next_bit,
    output logic ack,
    output logic encoded_out,
    output logic bridge_a,
    output logic bridge_b,
    output logic busy
);

    localparam int unsigned CYC_PER_US = CLK_FREQ_HZ / 1_000_000;
    localparam int unsigned H1         = CYC_PER_US * ONE_HALF_US;
    localparam int unsigned H0         = CYC_PER_US * ZERO_HALF_US;

    localparam logic [CNT_W-1:0] H1_LOAD   = CNT_W'(H1 - 1);
    localparam logic [CNT_W-1:0] H0_LOAD   = CNT_W'(H0 - 1);
    localparam logic [CNT_W-1:0] DEAD_LOAD = CNT_W'(DEAD_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIRST  = 2'd1,
        SECOND = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] dead_q, dead_d;
    logic             cur_bit_q, cur_bit_d;
    logic             enc_q, enc_d;
    logic             ack_q, ack_d;
    logic             busy_q, busy_d;
    logic             bridge_a_q, bridge_a_d;
    logic             bridge_b_q, bridge_b_d;
    logic             start;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cur_bit_d = cur_bit_q;
        enc_d     = enc_q;
        busy_d    = busy_q;
        start     = 1'b0;

        case (state_q)
            IDLE: begin
                enc_d  = 1'b0;
                busy_d = 1'b0;
                start  = enable;
            end
            FIRST: begin
                if (cnt_q == '0) begin
                    cnt_d   = cur_bit_q ? H1_LOAD : H0_LOAD;
                    enc_d   = 1'b0;
                    state_d = SECOND;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            SECOND: begin
                if (cnt_q == '0) begin
                    if (enable) begin
                        start = 1'b1;
                    end else begin
                        enc_d   = 1'b0;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d   = IDLE;
                cnt_d     = '0;
                cur_bit_d = 1'b0;
                enc_d     = 1'b0;
                busy_d    = 1'b0;
            end
        endcase

        // Shared capture path for IDLE start and back-to-back bits at the boundary.
        if (start) begin
            cur_bit_d = next_bit;
            cnt_d     = next_bit ? H1_LOAD : H0_LOAD;
            enc_d     = 1'b1;
            busy_d    = 1'b1;
            state_d   = FIRST;
        end

        ack_d = enc_d;

        // Dead counter reloads on the edge that makes a new level visible, so
        // the legs stay low for DEAD_CYCLES cycles starting with that one.
        if (enc_d != enc_q) begin
            dead_d = DEAD_LOAD;
        end else if (dead_q != '0) begin
            dead_d = dead_q - CNT_ONE;
        end else begin
            dead_d = '0;
        end

        bridge_a_d = busy_d &&  enc_d && (dead_d == '0);
        bridge_b_d = busy_d && !enc_d && (dead_d == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            dead_q     <= '0;
            cur_bit_q  <= 1'b0;
            enc_q      <= 1'b0;
            ack_q      <= 1'b0;
            busy_q     <= 1'b0;
            bridge_a_q <= 1'b0;
            bridge_b_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dead_q     <= dead_d;
            cur_bit_q  <= cur_bit_d;
            enc_q      <= enc_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
            bridge_a_q <= bridge_a_d;
            bridge_b_q <= bridge_b_d;
        end
    end

    assign ack         = ack_q;
    assign encoded_out = enc_q;
    assign bridge_a    = bridge_a_q;
    assign bridge_b    = bridge_b_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_dcc_bit_encoder.sv
// Bench for dcc_bit_encoder: stream table, multi-cycle corner sequences and a
// randomized run, all checked against a bit-position reference model.
module tb_dcc_bit_encoder;

    localparam int CLK_HZ = 1_000_000;
    localparam int H1     = (CLK_HZ / 1_000_000) * 58;
    localparam int H0     = (CLK_HZ / 1_000_000) * 100;
    localparam int DEAD   = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic enable = 1'b0;
    logic next_bit = 1'b0;
    logic ack0, enc0, a0, b0, busy0;
    logic ack1, enc1, a1, b1, busy1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dcc_bit_encoder #(
        .CLK_FREQ_HZ(CLK_HZ), .ONE_HALF_US(58), .ZERO_HALF_US(100),
        .DEAD_CYCLES(DEAD), .CNT_W(16)
    ) u0 (
        .clk(clk), .reset(reset), .enable(enable), .next_bit(next_bit),
        .ack(ack0), .encoded_out(enc0), .bridge_a(a0), .bridge_b(b0), .busy(busy0)
    );

    dcc_bit_encoder #(
        .CLK_FREQ_HZ(CLK_HZ), .ONE_HALF_US(58), .ZERO_HALF_US(100),
        .DEAD_CYCLES(0), .CNT_W(16)
    ) u1 (
        .clk(clk), .reset(reset), .enable(enable), .next_bit(next_bit),
        .ack(ack1), .encoded_out(enc1), .bridge_a(a1), .bridge_b(b1), .busy(busy1)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
        end
    endtask

    // Reference model: a bit occupies 2*H cycles, high for the first H.
    logic m_busy = 1'b0, m_bit = 1'b0, m_enc = 1'b0;
    int   m_pos = 0, m_since = 1000;
    logic n_busy, n_bit, n_enc;
    int   n_pos;

    function automatic int half(input logic b);
        return b ? H1 : H0;
    endfunction

    always_comb begin
        n_busy = m_busy;
        n_bit  = m_bit;
        n_pos  = m_pos;
        if (!m_busy) begin
            if (enable) begin
                n_busy = 1'b1;
                n_bit  = next_bit;
                n_pos  = 0;
            end
        end else if (m_pos + 1 == 2 * half(m_bit)) begin
            n_pos = 0;
            if (enable) n_bit = next_bit;
            else        n_busy = 1'b0;
        end else begin
            n_pos = m_pos + 1;
        end
        n_enc = n_busy && (n_pos < half(n_bit));
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy  <= 1'b0;
            m_bit   <= 1'b0;
            m_pos   <= 0;
            m_enc   <= 1'b0;
            m_since <= 1000;
        end else begin
            m_busy  <= n_busy;
            m_bit   <= n_bit;
            m_pos   <= n_pos;
            m_enc   <= n_enc;
            m_since <= (n_enc != m_enc) ? 0 : ((m_since < 1000) ? m_since + 1 : m_since);
        end
    end

    always @(negedge clk) begin
        logic [4:0] exp0, exp1;
        exp0 = {m_busy, m_enc, m_enc, m_busy && m_enc && (m_since >= DEAD),
                m_busy && !m_enc && (m_since >= DEAD)};
        exp1 = {m_busy, m_enc, m_enc, m_busy && m_enc, m_busy && !m_enc};
        chk("model_u0", int'({busy0, ack0, enc0, a0, b0}), int'(exp0));
        chk("model_u1", int'({busy1, ack1, enc1, a1, b1}), int'(exp1));
        chk("legs_excl_u0", int'(a0 & b0), 0);
        chk("legs_excl_u1", int'(a1 & b1), 0);
    end

    // Counts cycles while encoded_out holds val; at cycle upd_at drives the upstream inputs.
    task automatic measure(input logic val, input int upd_at, input logic nb, input logic en,
                           output int n, output int gap);
        n = 0;
        gap = 0;
        while (enc0 === val && busy0 === 1'b1 && n < 1000) begin
            if (n == upd_at) begin
                next_bit = nb;
                enable   = en;
            end
            if ((val ? a0 : b0) === 1'b0 && gap == n) gap++;
            @(negedge clk);
            n++;
        end
    endtask

    typedef struct {
        logic b;
        int   hi;
        int   lo;
        int   gap;
    } vec_t;

    vec_t vecs[5];
    int hi, lo, ga, gb;

    initial begin
        vecs[0] = '{1'b1, 58, 58, 8};
        vecs[1] = '{1'b0, 100, 100, 8};
        vecs[2] = '{1'b1, 58, 58, 8};
        vecs[3] = '{1'b1, 58, 58, 8};
        vecs[4] = '{1'b0, 100, 100, 8};

        #1 reset = 1'b1;
        #2 chk("reset_state", int'({ack0, enc0, a0, b0, busy0, ack1, enc1, a1, b1, busy1}), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_no_enable", int'({ack0, enc0, a0, b0, busy0}), 0);

        // Stream 1,0,1,1,0 with next_bit updated one cycle after each ack rise.
        next_bit = vecs[0].b;
        enable   = 1'b1;
        @(negedge clk);
        chk("start_latency", int'(enc0), 1);
        for (int i = 0; i < 5; i++) begin
            measure(1'b1, 1, (i < 4) ? vecs[(i < 4) ? i + 1 : 0].b : 1'b0, i < 4, hi, ga);
            measure(1'b0, -1, 1'b0, 1'b0, lo, gb);
            chk($sformatf("hi_len[%0d]", i), hi, vecs[i].hi);
            chk($sformatf("lo_len[%0d]", i), lo, vecs[i].lo);
            chk($sformatf("dead_a[%0d]", i), ga, vecs[i].gap);
            chk($sformatf("dead_b[%0d]", i), gb, vecs[i].gap);
        end
        chk("idle_after_stream", int'({ack0, enc0, a0, b0, busy0, ack1, enc1, a1, b1, busy1}), 0);

        // next_bit toggled mid-bit only affects the following bit.
        next_bit = 1'b0;
        enable   = 1'b1;
        @(negedge clk);
        chk("start_latency2", int'(enc0), 1);
        measure(1'b1, 30, 1'b1, 1'b1, hi, ga);
        measure(1'b0, -1, 1'b0, 1'b0, lo, gb);
        chk("toggle_cur_hi", hi, 100);
        chk("toggle_cur_lo", lo, 100);
        measure(1'b1, -1, 1'b0, 1'b0, hi, ga);
        chk("toggle_next_hi", hi, 58);
        next_bit = 1'b0;
        measure(1'b0, -1, 1'b0, 1'b0, lo, gb);
        chk("toggle_next_lo", lo, 58);

        // enable dropped 30 cycles into a "0" bit: the bit still completes.
        measure(1'b1, 30, 1'b0, 1'b0, hi, ga);
        measure(1'b0, -1, 1'b0, 1'b0, lo, gb);
        chk("drop_hi", hi, 100);
        chk("drop_lo", lo, 100);
        chk("idle_after_drop", int'({ack0, enc0, a0, b0, busy0}), 0);
        repeat (4) @(negedge clk);
        chk("idle_stays", int'({ack0, enc0, a0, b0, busy0}), 0);
        next_bit = 1'b1;
        enable   = 1'b1;
        @(negedge clk);
        chk("restart_latency", int'(enc0), 1);
        measure(1'b1, -1, 1'b0, 1'b0, hi, ga);
        measure(1'b0, -1, 1'b0, 1'b0, lo, gb);
        chk("restart_hi", hi, 58);
        chk("restart_lo", lo, 58);

        // Asynchronous reset in the middle of the first half.
        repeat (10) @(negedge clk);
        #1 reset = 1'b1;
        #1 chk("async_reset", int'({ack0, enc0, a0, b0, busy0, ack1, enc1, a1, b1, busy1}), 0);
        repeat (2) @(negedge clk);
        next_bit = 1'b0;
        reset    = 1'b0;
        @(negedge clk);
        chk("restart_after_reset", int'(enc0), 1);
        measure(1'b1, -1, 1'b0, 1'b1, hi, ga);
        chk("len_after_reset", hi, 100);

        // Randomized inputs with rare reset pulses; the model checker covers every cycle.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            next_bit = 1'($urandom_range(0, 1));
            enable   = ($urandom_range(0, 99) < 85);
            if ($urandom_range(0, 499) == 0) begin
                #2 reset = 1'b1;
                #1 reset = 1'b0;
            end
        end
        enable = 1'b0;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at %0t", $time);
        $fatal(1, "time limit");
    end

endmodule
